ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000: clock-inhibit hold, 100 us at 100 MHz.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1500000: per-attempt frame timeout, 15 ms at 100 MHz.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, 100 MHz. This is the only clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tx_valid, input, 1 bit: command byte request.
REQ-006 SHALL have port tx_data, input, 8 bits: command byte, e.g. 8'hED for set-LEDs.
REQ-007 SHALL have port tx_ready, output, 1 bit: high when a request can be accepted.
REQ-008 SHALL have port tx_done, output, 1 bit: one-cycle pulse on acknowledged frame.
REQ-009 SHALL have port tx_err, output, 1 bit: one-cycle pulse on no-ack or timeout.
REQ-010 SHALL have port tx_busy, output, 1 bit: high from accept until done/err. Used to gate the keyboard decoder.
REQ-011 SHALL have port ps2_clk_in, input, 1 bit: sampled PS2_CLK line.
REQ-012 SHALL have port ps2_data_in, input, 1 bit: sampled PS2_DATA line.
REQ-013 SHALL have port ps2_clk_oe, output, 1 bit: 1 pulls PS2_CLK low, 0 releases it (open-drain).
REQ-014 SHALL have port ps2_data_oe, output, 1 bit: 1 pulls PS2_DATA low, 0 releases it.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers. A PS/2 falling edge is synced clock 1 followed by 0.
REQ-016 SHALL accept a request when tx_valid && tx_ready. On accept: latch tx_data, compute parity = ~^tx_data (odd parity).
REQ-017 SHALL drive tx_ready=1 only in IDLE. tx_valid outside IDLE SHALL be ignored.
REQ-018 SHALL have FSM states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, FINISH.
REQ-019 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. ps2_data_oe SHALL be set to 1 in the last of those cycles.
REQ-020 REQ: release the clock (ps2_clk_oe=0) while holding data low (the start bit). Start the timeout counter. Go to SHIFT.
REQ-021 SHIFT, falling edges 1-8: ps2_data_oe = ~D[k], k=0..7, LSB first.
REQ-022 SHIFT, falling edge 9: ps2_data_oe = ~parity.
REQ-023 SHIFT, falling edge 10: ps2_data_oe = 0 (stop bit). Go to ACK.
REQ-024 ACK: at falling edge 11, synced data=0 means ack → WAIT_IDLE. Synced data=1 means no-ack → FINISH with error.
REQ-025 WAIT_IDLE: when synced clk and data are both 1 → FINISH with success.
REQ-026 FINISH: pulse tx_done or tx_err for one cycle. Enter IDLE the next cycle. tx_ready returns 1 in that IDLE cycle.
REQ-027 Timeout: if the counter reaches TIMEOUT_CYCLES in REQ, SHIFT, ACK or WAIT_IDLE, release both lines and end the attempt as an error.
REQ-028 The timeout counter SHALL saturate, never wrap, and clear on each new attempt.
REQ-029 tx_busy SHALL be 1 in every state except IDLE.
REQ-030 tx_done and tx_err SHALL never be high in the same cycle.
REQ-031 SHALL release both ps2_clk_oe and ps2_data_oe in IDLE, WAIT_IDLE and FINISH.
REQ-032 SHALL use the falling-edge count to select the bit to drive (counter 0-11, no shift-out past bit 11).

Reset
REQ-033 rst=0 SHALL immediately set state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, tx_busy=0, counters=0, retry count=0.
REQ-034 tx_ready SHALL be 0 while rst=0 and 1 from the first clk edge after rst=1.
REQ-035 Reset mid-frame SHALL release both lines and SHALL NOT emit tx_done or tx_err.

Configuration
REQ-036 Macro PS2_HOST_TX_RETRY_EN.
- Defined: on no-ack or timeout, re-enter INHIBIT with the latched byte. Up to 2 retries (3 attempts total). tx_err pulses only after the 3rd failed attempt. tx_busy stays 1 throughout.
- Undefined: the first failure pulses tx_err. The retry counter SHALL be absent.

Verification
REQ-037 Send 8'hED, device model acks → data sampled on rising edges: 0,1,0,1,1,0,1,1,1,1 (start, D0-D7, parity=1), then stop=1. One tx_done pulse; tx_err=0.
REQ-038 Send 8'h07 → parity bit 0; ps2_clk_oe high for exactly 10000 cycles before release; tx_done pulses once.
REQ-039 Device clocks 11 edges but holds data high at edge 11 → macro off: tx_err pulse after 1 attempt. Macro on: 3 INHIBIT phases, then tx_err.
REQ-040 Device never clocks → tx_err exactly 1500000 cycles after clock release (macro off); both oe=0 afterwards.
REQ-041 rst=0 asserted after edge 5 → both oe=0 in the same cycle; no done/err pulse; tx_ready=1 one cycle after rst=1.
REQ-042 tx_valid held high with 8'h00 through a full transfer → exactly one frame sent (parity 1). A second accept occurs in the IDLE cycle after tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ack check.
// Optional macro PS2_HOST_TX_RETRY_EN: up to two automatic retries before reporting tx_err.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       tx_busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] dbg_state
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t          state, state_n;
  logic            clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
  logic            fall, accept, timed, tout, fail, fin_err;
  logic            ready_en, par_q, drive_q, err_q;
  logic [7:0]      data_q;
  logic [IW-1:0]   inh_cnt;
  logic [TW-1:0]   to_cnt;
  logic [3:0]      edge_cnt;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]      retry_q;
  logic            retry_inc;
`endif

  // Bus idles high, so synchronizers reset to 1 to avoid a phantom falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
    end
  end

  assign fall   = clk_d & ~clk_s2;
  // Handshake: a byte transfers on any clk edge where tx_valid && tx_ready; tx_ready is high only in IDLE.
  assign accept = tx_valid & tx_ready;
  assign timed  = (state == S_REQ) || (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign tout   = timed && (to_cnt >= TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n = state;
    fail    = 1'b0;
    fin_err = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_inc = 1'b0;
`endif
    case (state)
      S_IDLE:      if (accept) state_n = S_INHIBIT;
      S_INHIBIT:   if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) state_n = S_REQ;
      S_REQ:       state_n = S_SHIFT;
      S_SHIFT:     if (fall && edge_cnt == 4'd9) state_n = S_ACK;
      S_ACK: begin
        if (fall) begin
          if (dat_s2) fail = 1'b1;
          else        state_n = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: if (clk_s2 && dat_s2) state_n = S_FINISH;
      S_FINISH:    state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    if (tout) fail = 1'b1;
    if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        state_n   = S_INHIBIT;
        retry_inc = 1'b1;
      end else begin
        state_n = S_FINISH;
        fin_err = 1'b1;
      end
`else
      state_n = S_FINISH;
      fin_err = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ready_en <= 1'b0;
      data_q   <= '0;
      par_q    <= 1'b0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      edge_cnt <= '0;
      drive_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      ready_en <= 1'b1;
      if (accept) begin
        data_q <= tx_data;
        par_q  <= ~^tx_data;
      end
      inh_cnt <= (state == S_INHIBIT) ? inh_cnt + IW'(1) : '0;
      if (state == S_INHIBIT)
        to_cnt <= '0;
      else if (timed && to_cnt != TW'(TIMEOUT_CYCLES))
        to_cnt <= to_cnt + TW'(1);
      if (state == S_REQ)
        edge_cnt <= '0;
      else if (fall && (state == S_SHIFT || state == S_ACK) && edge_cnt != 4'd11)
        edge_cnt <= edge_cnt + 4'd1;
      // drive_q is the pull-low enable: start bit, inverted data, inverted parity, then released stop bit.
      if (state == S_REQ)
        drive_q <= 1'b1;
      else if (state == S_SHIFT && fall) begin
        if (edge_cnt < 4'd8)       drive_q <= ~data_q[edge_cnt[2:0]];
        else if (edge_cnt == 4'd8) drive_q <= ~par_q;
        else                       drive_q <= 1'b0;
      end
      if (state_n == S_FINISH && state != S_FINISH) err_q <= fin_err;
    end
  end

`ifdef PS2_HOST_TX_RETRY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           retry_q <= 2'd0;
    else if (accept)    retry_q <= 2'd0;
    else if (retry_inc) retry_q <= retry_q + 2'd1;
  end
`endif

  assign tx_ready    = ready_en && (state == S_IDLE);
  assign tx_busy     = (state != S_IDLE);
  assign tx_done     = (state == S_FINISH) && !err_q;
  assign tx_err      = (state == S_FINISH) && err_q;
  assign ps2_clk_oe  = (state == S_INHIBIT);
  assign ps2_data_oe = ((state == S_INHIBIT) && (inh_cnt == IW'(INHIBIT_CYCLES - 1))) ||
                       (state == S_REQ) || ((state == S_SHIFT) && drive_q);
  assign dbg_state   = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TO   = 3000;
  localparam int HALF = 20;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err, tx_busy;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic [2:0] dbg_state;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .tx_busy(tx_busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observers, updated with NBAs so reads from the stimulus block see a stable value.
  int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_phases = 0;
  int   inh_run = 0, last_inh_len = 0, rel_cyc = 0, err_cyc = 0, done_cyc = 0;
  int   acc_cnt = 0, acc_cyc = 0;
  logic prev_oe = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_oe   <= ps2_clk_oe;
    prev_busy <= tx_busy;
    if (tx_done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (tx_err)  begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe) inh_run <= inh_run + 1;
    else if (prev_oe) begin
      last_inh_len <= inh_run;
      inh_run      <= 0;
      inh_phases   <= inh_phases + 1;
      rel_cyc      <= cyc;
    end
    if (tx_busy && !prev_busy) begin acc_cnt <= acc_cnt + 1; acc_cyc <= cyc; end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    int i;
    for (i = 0; i < 10 && !ps2_clk_oe; i++) tick(1);
    for (i = 0; i < INH + 20 && ps2_clk_oe; i++) tick(1);
    ok = !ps2_clk_oe;
    tick(10);
  endtask

  // Device clocks eleven pulses, sampling the line late in each high phase.
  task automatic dev_frame(input bit ack, output logic [10:0] bits, output bit ok);
    bits = '0;
    wait_release(ok);
    for (int i = 0; i < 11; i++) begin
      bits[i] = ps2_data_in;
      if (i == 10 && ack) begin
        dev_data = 1'b0;
        tick(2);
      end
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      tick(HALF);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_end(input int d0, input int e0, input int bound, output bit ok);
    int i;
    for (i = 0; i < bound && done_cnt == d0 && err_cnt == e0; i++) tick(1);
    ok = (done_cnt != d0) || (err_cnt != e0);
    tick(3);
  endtask

  logic [10:0] bits, exp_bits;
  bit          ok;
  int          d0, e0, p0, a0;

  initial begin
    // Reset state
    rst = 1'b0;
    tick(3);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    tick(1);
    check("ready_after_rst", tx_ready, 1);

    // 8'hED with ack: start 0, D0..D7 = 1,0,1,1,0,1,1,1, parity 1, stop 1
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    check("ed_busy", tx_busy, 1);
    check("ed_ready_low", tx_ready, 0);
    dev_frame(1'b1, bits, ok);
    check("ed_release", ok, 1);
    exp_bits = {1'b1, 1'b1, 8'hED, 1'b0};
    check("ed_bits", bits, exp_bits);
    check("ed_inhibit_len", last_inh_len, INH);
    wait_end(d0, e0, 500, ok);
    check("ed_end_wait", ok, 1);
    check("ed_done_cnt", done_cnt - d0, 1);
    check("ed_err_cnt", err_cnt - e0, 0);
    check("ed_ready_back", tx_ready, 1);
    check("ed_busy_back", tx_busy, 0);

    // 8'h07: parity 0
    d0 = done_cnt; e0 = err_cnt;
    send(8'h07);
    dev_frame(1'b1, bits, ok);
    exp_bits = {1'b1, 1'b0, 8'h07, 1'b0};
    check("b07_bits", bits, exp_bits);
    check("b07_inhibit_len", last_inh_len, INH);
    wait_end(d0, e0, 500, ok);
    check("b07_done_cnt", done_cnt - d0, 1);
    check("b07_err_cnt", err_cnt - e0, 0);

    // No-ack on 8'hA5 (parity 1)
    d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
    send(8'hA5);
    for (int a = 0; a < ATTEMPTS; a++) dev_frame(1'b0, bits, ok);
    exp_bits = {1'b1, 1'b1, 8'hA5, 1'b0};
    check("nak_bits", bits, exp_bits);
    wait_end(d0, e0, 500, ok);
    check("nak_end_wait", ok, 1);
    check("nak_err_cnt", err_cnt - e0, 1);
    check("nak_done_cnt", done_cnt - d0, 0);
    check("nak_inhibits", inh_phases - p0, ATTEMPTS);

    // Device never clocks
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55);
    wait_end(d0, e0, ATTEMPTS * (INH + TO + 50) + 100, ok);
    check("to_end_wait", ok, 1);
    check("to_err_cnt", err_cnt - e0, 1);
    check("to_done_cnt", done_cnt - d0, 0);
    check("to_latency", err_cyc - rel_cyc, TO);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);

    // Reset after falling edge 5 of 8'h2C (D4 = 0, so data is being pulled low)
    d0 = done_cnt; e0 = err_cnt;
    send(8'h2C);
    wait_release(ok);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0; tick(HALF);
      dev_clk = 1'b1; tick(HALF);
    end
    dev_clk = 1'b0;
    tick(6);
    check("mid_data_driven", ps2_data_oe, 1);
    rst = 1'b0;
    #1;
    check("mid_clk_oe", ps2_clk_oe, 0);
    check("mid_data_oe", ps2_data_oe, 0);
    check("mid_busy", tx_busy, 0);
    tick(3);
    dev_clk = 1'b1;
    tick(HALF);
    rst = 1'b1;
    check("mid_ready_in_rst", tx_ready, 0);
    tick(1);
    check("mid_ready_after", tx_ready, 1);
    tick(5);
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_no_err", err_cnt - e0, 0);

    // tx_valid held high with 8'h00 (parity 1)
    d0 = done_cnt; e0 = err_cnt; p0 = inh_phases; a0 = acc_cnt;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick(1);
    dev_frame(1'b1, bits, ok);
    exp_bits = {1'b1, 1'b1, 8'h00, 1'b0};
    check("hold_bits", bits, exp_bits);
    wait_end(d0, e0, 500, ok);
    tx_valid = 1'b0;
    check("hold_done_cnt", done_cnt - d0, 1);
    check("hold_one_frame", inh_phases - p0, 1);
    check("hold_accepts", acc_cnt - a0, 2);
    check("hold_reaccept_cyc", acc_cyc - done_cyc, 2);
    dev_frame(1'b1, bits, ok);
    wait_end(d0 + 1, e0, 500, ok);
    check("hold_second_done", done_cnt - d0, 2);
    check("hold_second_err", err_cnt - e0, 0);

    check("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
